// File: rtl/tracking_pkg.sv
// Shared types and helpers for the tracking front-end sequencer.
package tracking_pkg;

  localparam int unsigned TRK_COORD_W = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    STREAM = 3'd2,
    SKIP   = 3'd3,
    DRAIN  = 3'd4
  } ctrl_state_t;

  typedef struct packed {
    logic [TRK_COORD_W-1:0] center_x;
    logic [TRK_COORD_W-1:0] center_y;
    logic [TRK_COORD_W-1:0] width;
    logic [TRK_COORD_W-1:0] height;
  } trk_result_t;

  // Miss counter increment that holds at its 4-bit ceiling.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    logic [3:0] r;
    if (v == 4'd15) begin
      r = 4'd15;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Per-frame beat counter shared by the STREAM and SKIP states.
// Wraps to zero on the beat that completes a frame so the next frame starts clean.
module frame_pixel_counter #(
  parameter int unsigned TOTAL = 307200,
  parameter int unsigned CW    = 19
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, terminal beat wraps, otherwise step per beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/tracking_ctrl.sv
// Frame sequencer in front of the tracker: aligns to start-of-frame, forwards
// whole frames, decimates, waits for a result with timeout, and reports status.
module tracking_ctrl
  import tracking_pkg::*;
#(
  parameter int unsigned WIDTH          = 640,
  parameter int unsigned HEIGHT         = 480,
  parameter int unsigned RESULT_TIMEOUT = 8192,
  parameter int unsigned LOST_FRAMES    = 4
) (
  input  logic                   clock_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3:0]             skip,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  input  logic [23:0]            pix_data,
  output logic                   pix_ready,
  output logic                   trk_wr_en,
  output logic [23:0]            trk_din,
  input  logic                   trk_full,
  input  logic                   trk_valid,
  input  logic [TRK_COORD_W-1:0] trk_center_x,
  input  logic [TRK_COORD_W-1:0] trk_center_y,
  input  logic [TRK_COORD_W-1:0] trk_width,
  input  logic [TRK_COORD_W-1:0] trk_height,
  output logic                   res_valid,
  output logic [TRK_COORD_W-1:0] res_center_x,
  output logic [TRK_COORD_W-1:0] res_center_y,
  output logic [TRK_COORD_W-1:0] res_width,
  output logic [TRK_COORD_W-1:0] res_height,
  output logic                   locked,
  output logic                   lost,
  output logic                   sync_err,
  output logic [15:0]            frame_count
);

  localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
  localparam int unsigned PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int unsigned TMR_W     = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESULT_TIMEOUT - 1);
  localparam logic [4:0]       LOST_TH  = 5'(LOST_FRAMES);

  ctrl_state_t state_q;
  trk_result_t res_q;
  logic        res_valid_q;
  logic        locked_q;
  logic        lost_q;
  logic        sync_err_q;
  logic [15:0] frame_count_q;
  logic [3:0]  skip_cnt_q;
  logic [3:0]  miss_cnt_q;
  logic [TMR_W-1:0] timer_q;

  logic             pix_ready_s;
  logic             trk_wr_en_s;
  logic             cnt_en_s;
  logic             cnt_clr_s;
  logic [PIX_W-1:0] pix_cnt_s;
  logic             pix_tc_s;
  logic             drain_done_s;
  logic             lost_hit_s;

  // Handshake decode per state; reset forces the idle handshake immediately.
  always_comb begin
    pix_ready_s = 1'b1;
    trk_wr_en_s = 1'b0;
    if (!reset) begin
      pix_ready_s = 1'b1;
      trk_wr_en_s = 1'b0;
    end else begin
      case (state_q)
        IDLE:    pix_ready_s = 1'b1;
        SYNC:    pix_ready_s = !pix_sof;
        STREAM: begin
          pix_ready_s = !trk_full;
          trk_wr_en_s = pix_valid && !trk_full;
        end
        SKIP:    pix_ready_s = 1'b1;
        DRAIN:   pix_ready_s = 1'b0;
        default: pix_ready_s = 1'b1;
      endcase
    end
  end

  // Counter runs on accepted beats only while a frame body is being consumed.
  always_comb begin
    cnt_en_s  = 1'b0;
    cnt_clr_s = 1'b1;
    if ((state_q == STREAM) || (state_q == SKIP)) begin
      cnt_en_s  = pix_valid && pix_ready_s;
      cnt_clr_s = 1'b0;
    end else begin
      cnt_en_s  = 1'b0;
      cnt_clr_s = 1'b1;
    end
  end

  assign drain_done_s = (state_q == DRAIN) && (trk_valid || (timer_q == TMR_LAST));
  assign lost_hit_s   = (({1'b0, miss_cnt_q} + 5'd1) >= LOST_TH);

  frame_pixel_counter #(
    .TOTAL (FRAME_PIX),
    .CW    (PIX_W)
  ) u_pix_cnt (
    .clk_i  (clock_50),
    .rst_ni (reset),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .cnt_o  (pix_cnt_s),
    .tc_o   (pix_tc_s)
  );

  // Frame sequencer with registered result and status outputs.
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state_q       <= IDLE;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= 16'd0;
      skip_cnt_q    <= 4'd0;
      miss_cnt_q    <= 4'd0;
      timer_q       <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (enable) begin
            state_q <= SYNC;
          end
        end
        SYNC: begin
          timer_q <= '0;
          if (pix_valid && pix_sof) begin
            if (!enable) begin
              state_q <= IDLE;
            end else if (skip_cnt_q == 4'd0) begin
              state_q <= STREAM;
            end else begin
              state_q <= SKIP;
            end
          end
        end
        STREAM: begin
          if (cnt_en_s) begin
            // A second start-of-frame inside the body is kept as data but flagged.
            if (pix_sof && (pix_cnt_s != '0)) begin
              sync_err_q <= 1'b1;
            end
            if (pix_tc_s) begin
              state_q <= DRAIN;
              timer_q <= '0;
            end
          end
        end
        SKIP: begin
          if (cnt_en_s && pix_tc_s) begin
            skip_cnt_q <= skip_cnt_q - 4'd1;
            state_q    <= enable ? SYNC : IDLE;
          end
        end
        DRAIN: begin
          timer_q <= timer_q + TMR_W'(1);
          if (trk_valid) begin
            res_q.center_x <= trk_center_x;
            res_q.center_y <= trk_center_y;
            res_q.width    <= trk_width;
            res_q.height   <= trk_height;
            res_valid_q    <= 1'b1;
            locked_q       <= 1'b1;
            lost_q         <= 1'b0;
            miss_cnt_q     <= 4'd0;
          end else if (timer_q == TMR_LAST) begin
            miss_cnt_q <= sat_inc4(miss_cnt_q);
            locked_q   <= 1'b0;
            lost_q     <= lost_q | lost_hit_s;
          end
          if (drain_done_s) begin
            frame_count_q <= frame_count_q + 16'd1;
            skip_cnt_q    <= skip;
            state_q       <= enable ? SYNC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_ready    = pix_ready_s;
  assign trk_wr_en    = trk_wr_en_s;
  assign trk_din      = pix_data;
  assign res_valid    = res_valid_q;
  assign res_center_x = res_q.center_x;
  assign res_center_y = res_q.center_y;
  assign res_width    = res_q.width;
  assign res_height   = res_q.height;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign sync_err     = sync_err_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_tracking_ctrl.sv
// Scoreboard bench for tracking_ctrl with a small 8x4 frame geometry.
module tb_tracking_ctrl;

  localparam int NPIX = 32;

  logic        clock_50 = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  skip = 4'd0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [23:0] pix_data = 24'd0;
  logic        pix_ready;
  logic        trk_wr_en;
  logic [23:0] trk_din;
  logic        trk_full = 1'b0;
  logic        trk_valid = 1'b0;
  logic [11:0] trk_center_x = 12'd0;
  logic [11:0] trk_center_y = 12'd0;
  logic [11:0] trk_width = 12'd0;
  logic [11:0] trk_height = 12'd0;
  logic        res_valid;
  logic [11:0] res_center_x;
  logic [11:0] res_center_y;
  logic [11:0] res_width;
  logic [11:0] res_height;
  logic        locked;
  logic        lost;
  logic        sync_err;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [23:0] wr_q[$];
  logic [47:0] res_q[$];

  tracking_ctrl #(
    .WIDTH(8), .HEIGHT(4), .RESULT_TIMEOUT(16), .LOST_FRAMES(2)
  ) dut (
    .clock_50(clock_50), .reset(reset), .enable(enable), .skip(skip),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .pix_ready(pix_ready), .trk_wr_en(trk_wr_en), .trk_din(trk_din),
    .trk_full(trk_full), .trk_valid(trk_valid),
    .trk_center_x(trk_center_x), .trk_center_y(trk_center_y),
    .trk_width(trk_width), .trk_height(trk_height),
    .res_valid(res_valid), .res_center_x(res_center_x),
    .res_center_y(res_center_y), .res_width(res_width),
    .res_height(res_height), .locked(locked), .lost(lost),
    .sync_err(sync_err), .frame_count(frame_count)
  );

  always #5 clock_50 = ~clock_50;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int f, input int i);
    return {f[7:0], i[15:0]};
  endfunction

  // Scoreboard side: every write and every result pulse is matched against the queues.
  always @(negedge clock_50) begin
    if (trk_wr_en) begin
      wr_cnt++;
      check_eq("wr_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) check_eq("wr_data", 64'(trk_din), 64'(wr_q.pop_front()));
    end
    if (res_valid) begin
      check_eq("res_expected", 64'(res_q.size() != 0), 64'd1);
      if (res_q.size() != 0)
        check_eq("res_data", 64'({res_center_x, res_center_y, res_width, res_height}),
                 64'(res_q.pop_front()));
    end
  end

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; trk_full = 1'b0; trk_valid = 1'b0;
    pix_valid = 1'b1; pix_sof = 1'b0;
    @(posedge clock_50); #1;
    check_eq("rst_ready", 64'(pix_ready), 64'd1);
    check_eq("rst_wr_en", 64'(trk_wr_en), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_res", 64'({res_center_x, res_center_y, res_width, res_height}), 64'd0);
    check_eq("rst_locked", 64'(locked), 64'd0);
    check_eq("rst_lost", 64'(lost), 64'd0);
    check_eq("rst_sync_err", 64'(sync_err), 64'd0);
    check_eq("rst_frame_count", 64'(frame_count), 64'd0);
    check_eq("rst_wr_q_empty", 64'(wr_q.size()), 64'd0);
    check_eq("rst_res_q_empty", 64'(res_q.size()), 64'd0);
    wr_q.delete(); res_q.delete();
    pix_valid = 1'b0;
    @(posedge clock_50); #1;
    reset = 1'b1;
    wr_cnt = 0;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic sof);
    bit acc;
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clock_50);
      acc = pix_ready;
      @(posedge clock_50); #1;
    end
    if (!acc) check_eq("beat_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_frame(input int fid, input bit fwd, input int sof_at,
                            input int full_at, input int drop_at);
    for (int i = 0; i < NPIX; i++) begin
      if (i == full_at) begin
        trk_full = 1'b1; pix_valid = 1'b1; pix_data = pix(fid, i); pix_sof = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock_50);
          check_eq("bp_ready", 64'(pix_ready), 64'd0);
          check_eq("bp_wr_en", 64'(trk_wr_en), 64'd0);
          @(posedge clock_50); #1;
        end
        trk_full = 1'b0;
      end
      if (i == drop_at) enable = 1'b0;
      if (fwd) wr_q.push_back(pix(fid, i));
      send_beat(pix(fid, i), (i == 0) || (i == sof_at));
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic give_result(input int dly, input logic [11:0] x, input logic [11:0] y,
                             input logic [11:0] w, input logic [11:0] h);
    repeat (dly) @(posedge clock_50);
    #1;
    trk_valid = 1'b1; trk_center_x = x; trk_center_y = y; trk_width = w; trk_height = h;
    res_q.push_back({x, y, w, h});
    @(posedge clock_50); #1;
    trk_valid = 1'b0;
    repeat (2) @(posedge clock_50);
    #1;
  endtask

  task automatic start_run();
    enable = 1'b1;
    repeat (2) @(posedge clock_50);
    #1;
  endtask

  initial begin
    // Basic frame, plus a stray result strobe outside DRAIN
    do_reset();
    start_run();
    trk_valid = 1'b1; trk_center_x = 12'd7;
    @(posedge clock_50); #1;
    trk_valid = 1'b0;
    @(posedge clock_50); #1;
    check_eq("stray_locked", 64'(locked), 64'd0);
    send_frame(1, 1'b1, -1, -1, -1);
    give_result(4, 12'd3, 12'd1, 12'd2, 12'd2);
    check_eq("basic_wr_cnt", 64'(wr_cnt), 64'd32);
    check_eq("basic_locked", 64'(locked), 64'd1);
    check_eq("basic_frame_count", 64'(frame_count), 64'd1);
    check_eq("basic_res_x", 64'(res_center_x), 64'd3);
    check_eq("basic_sync_err", 64'(sync_err), 64'd0);

    // Backpressure
    do_reset();
    start_run();
    send_frame(2, 1'b1, -1, 10, -1);
    give_result(3, 12'd10, 12'd20, 12'd30, 12'd40);
    check_eq("bp_wr_cnt", 64'(wr_cnt), 64'd32);
    check_eq("bp_q_empty", 64'(wr_q.size()), 64'd0);

    // Decimation with skip=2
    do_reset();
    skip = 4'd2;
    start_run();
    send_frame(3, 1'b1, -1, -1, -1);
    give_result(2, 12'd1, 12'd1, 12'd1, 12'd1);
    check_eq("dec_f1_wr", 64'(wr_cnt), 64'd32);
    send_frame(4, 1'b0, -1, -1, -1);
    send_frame(5, 1'b0, -1, -1, -1);
    check_eq("dec_skip_wr", 64'(wr_cnt), 64'd32);
    send_frame(6, 1'b1, -1, -1, -1);
    give_result(2, 12'd2, 12'd2, 12'd2, 12'd2);
    check_eq("dec_wr_cnt", 64'(wr_cnt), 64'd64);
    check_eq("dec_frame_count", 64'(frame_count), 64'd2);
    skip = 4'd0;

    // Timeout and lost
    do_reset();
    start_run();
    send_frame(7, 1'b1, -1, -1, -1);
    repeat (17) @(posedge clock_50);
    #1;
    check_eq("to1_locked", 64'(locked), 64'd0);
    check_eq("to1_lost", 64'(lost), 64'd0);
    check_eq("to1_frame_count", 64'(frame_count), 64'd1);
    send_frame(8, 1'b1, -1, -1, -1);
    repeat (15) @(posedge clock_50);
    #1;
    check_eq("to2_lost_before", 64'(lost), 64'd0);
    @(posedge clock_50); #1;
    check_eq("to2_lost_after", 64'(lost), 64'd1);
    check_eq("to2_frame_count", 64'(frame_count), 64'd2);
    send_frame(9, 1'b1, -1, -1, -1);
    give_result(3, 12'd5, 12'd6, 12'd7, 12'd8);
    check_eq("to3_lost", 64'(lost), 64'd0);
    check_eq("to3_locked", 64'(locked), 64'd1);
    check_eq("to3_frame_count", 64'(frame_count), 64'd3);

    // Sync: junk beats before sof, then a mid-frame sof
    do_reset();
    start_run();
    for (int i = 0; i < 5; i++) send_beat(pix(10, 100 + i), 1'b0);
    check_eq("sync_junk_wr", 64'(wr_cnt), 64'd0);
    send_frame(11, 1'b1, 20, -1, -1);
    check_eq("sync_err_set", 64'(sync_err), 64'd1);
    give_result(2, 12'd9, 12'd9, 12'd9, 12'd9);
    check_eq("sync_wr_cnt", 64'(wr_cnt), 64'd32);
    check_eq("sync_frame_count", 64'(frame_count), 64'd1);

    // Enable drop mid-frame
    do_reset();
    start_run();
    send_frame(12, 1'b1, -1, -1, 16);
    give_result(2, 12'd4, 12'd3, 12'd2, 12'd1);
    check_eq("drop_wr_cnt", 64'(wr_cnt), 64'd32);
    send_frame(13, 1'b0, -1, -1, -1);
    check_eq("drop_idle_wr", 64'(wr_cnt), 64'd32);
    check_eq("drop_frame_count", 64'(frame_count), 64'd1);

    // Reset in the middle of a stream after status has been built up
    do_reset();
    start_run();
    send_frame(14, 1'b1, -1, -1, -1);
    give_result(2, 12'hABC, 12'h123, 12'h456, 12'h789);
    for (int i = 0; i < 8; i++) begin
      wr_q.push_back(pix(15, i));
      send_beat(pix(15, i), (i == 0) || (i == 5));
    end
    check_eq("mid_pre_sync_err", 64'(sync_err), 64'd1);
    check_eq("mid_pre_locked", 64'(locked), 64'd1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
